// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register indices,
// data-memory access codes, FSM states and STATUS bit positions.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // Access codes match the ones the data-memory block decodes
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by a memory-mapped peripheral.
interface mmio_uart_tx_if #(
    parameter int BITNESS = 32
) ();
    logic [BITNESS-1:0] address;
    logic [BITNESS-1:0] write_data;
    logic               write_enable;
    logic [2:0]         DATAMEMControl;
    logic [BITNESS-1:0] read_data;

    modport master (
        output address, write_data, write_enable, DATAMEMControl,
        input  read_data
    );

    modport slave (
        input  address, write_data, write_enable, DATAMEMControl,
        output read_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop
// frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_dout   = r_mem[r_rptr];
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk_i) begin
        if (w_doPush) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wptr <= r_wptr + AW'(1);
            if (w_doPop)  r_rptr <= r_rptr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus, with a
// TX FIFO, programmable bit period and a drain interrupt.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int                 BITNESS     = 32,
    parameter logic [BITNESS-1:0] BASE_ADDR   = 32'h0001_0000,
    parameter int                 FIFO_DEPTH  = 8,
    parameter logic [15:0]        DEFAULT_DIV = 16'd868
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mmio_uart_tx_if.slave bus,
    output logic          tx_o,
    output logic          irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               w_sel, w_wr, w_isWord, w_push, w_pop, w_drop;
    logic [1:0]         w_idx;
    logic               w_full, w_empty, w_busy;
    logic [7:0]         w_dout;
    logic [CW-1:0]      w_count;
    logic [3:0]         w_countSat;
    logic [BITNESS-1:0] w_status, w_regWord;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_unused;

    logic               r_ovf, r_irqEn, r_irq, r_tx;
    logic [15:0]        r_baudDiv, r_divCnt, r_divQ;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_shreg;
    tx_state_t          r_state;

    tx_state_t          w_stateNext;
    logic [15:0]        w_divCntNext, w_divQNext;
    logic [2:0]         w_bitIdxNext;
    logic [7:0]         w_shregNext;
    logic               w_txNext;

    assign w_sel    = (bus.address[BITNESS-1:4] == BASE_ADDR[BITNESS-1:4]);
    assign w_idx    = bus.address[3:2];
    assign w_wr     = bus.write_enable & w_sel;
    assign w_isWord = (bus.DATAMEMControl == MEM_LW);
    assign w_push   = w_wr & (w_idx == REG_TXDATA);
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_busy   = (r_state != IDLE);
    assign w_unused = ^bus.write_data[BITNESS-1:16];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.write_data[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Overflow set wins over a same-edge software clear so no drop goes unseen
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf     <= 1'b0;
            r_baudDiv <= DEFAULT_DIV;
            r_irqEn   <= 1'b0;
        end else begin
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr && w_idx == REG_STATUS && bus.write_data[ST_OVF])
                r_ovf <= 1'b0;
            if (w_wr && w_isWord && w_idx == REG_BAUDDIV)
                r_baudDiv <= (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
            if (w_wr && w_isWord && w_idx == REG_CTRL)
                r_irqEn <= bus.write_data[0];
        end
    end

    assign w_countSat = (w_count > CW'(15)) ? 4'hF : 4'(w_count);
    assign w_status   = {{(BITNESS-8){1'b0}}, w_countSat, r_ovf, w_empty, w_full, w_busy};

    always_comb begin
        w_regWord = '0;
        case (w_idx)
            REG_STATUS:  w_regWord = w_status;
            REG_BAUDDIV: w_regWord = {{(BITNESS-16){1'b0}}, r_baudDiv};
            REG_CTRL:    w_regWord = {{(BITNESS-1){1'b0}}, r_irqEn};
            default:     w_regWord = '0;
        endcase
    end

    assign w_byte = w_regWord[{bus.address[1:0], 3'b000} +: 8];
    assign w_half = w_regWord[{bus.address[1], 4'b0000} +: 16];

    always_comb begin
        bus.read_data = '0;
        if (w_sel) begin
            case (bus.DATAMEMControl)
                MEM_LB:  bus.read_data = {{(BITNESS-8){w_byte[7]}}, w_byte};
                MEM_LBU: bus.read_data = {{(BITNESS-8){1'b0}}, w_byte};
                MEM_LH:  bus.read_data = {{(BITNESS-16){w_half[15]}}, w_half};
                MEM_LHU: bus.read_data = {{(BITNESS-16){1'b0}}, w_half};
                MEM_LW:  bus.read_data = w_regWord;
                default: bus.read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_divCnt <= '0;
            r_divQ   <= 16'd1;
            r_bitIdx <= '0;
            r_shreg  <= '0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_divCnt <= w_divCntNext;
            r_divQ   <= w_divQNext;
            r_bitIdx <= w_bitIdxNext;
            r_shreg  <= w_shregNext;
            r_tx     <= w_txNext;
            r_irq    <= r_irqEn & w_empty & (r_state == IDLE);
        end
    end

    // Divisor is latched per frame so BAUDDIV writes only affect later frames
    always_comb begin
        w_stateNext  = r_state;
        w_divCntNext = r_divCnt;
        w_divQNext   = r_divQ;
        w_bitIdxNext = r_bitIdx;
        w_shregNext  = r_shreg;
        w_txNext     = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_txNext = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shregNext  = w_dout;
                    w_divQNext   = r_baudDiv;
                    w_divCntNext = r_baudDiv - 16'd1;
                    w_txNext     = 1'b0;
                    w_stateNext  = START;
                end
            end
            START: begin
                if (r_divCnt == 16'd0) begin
                    w_divCntNext = r_divQ - 16'd1;
                    w_txNext     = r_shreg[0];
                    w_bitIdxNext = 3'd0;
                    w_stateNext  = DATA;
                end else begin
                    w_divCntNext = r_divCnt - 16'd1;
                end
            end
            DATA: begin
                if (r_divCnt == 16'd0) begin
                    w_divCntNext = r_divQ - 16'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_txNext    = 1'b1;
                        w_stateNext = STOP;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                        w_shregNext  = {1'b0, r_shreg[7:1]};
                        w_txNext     = r_shreg[1];
                    end
                end else begin
                    w_divCntNext = r_divCnt - 16'd1;
                end
            end
            STOP: begin
                if (r_divCnt == 16'd0)
                    w_stateNext = IDLE;
                else
                    w_divCntNext = r_divCnt - 16'd1;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign tx_o  = r_tx;
    assign irq_o = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level model of the FIFO and the
// serial line predicts tx_o, irq_o and every register load.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 8;
    localparam logic [2:0]  SB = 3'b000, SH = 3'b001, SW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic tx_o, irq_o;
    bit   chkEn = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    mmio_uart_tx_if #(.BITNESS(32)) bus ();

    mmio_uart_tx #(
        .BITNESS(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .tx_o  (tx_o),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: queued bytes plus the position inside the current frame.
    // A frame is 10 bit slots of mDiv clocks; frameClk < 0 means the line is idle.
    byte unsigned mq[$];
    int           frameClk = -1;
    logic [9:0]   frameBits = '1;
    int           mDiv = 1;
    int           mBaud = 868;
    bit           mOvf = 1'b0;
    bit           mIrqEn = 1'b0;
    bit           mIrq = 1'b0;

    task automatic modelStep();
        bit   wasIdle, popNow, dropped;
        int   preSize;
        byte unsigned b;
        logic [31:0] a, d;
        a       = bus.address;
        d       = bus.write_data;
        wasIdle = (frameClk < 0);
        preSize = mq.size();
        popNow  = wasIdle && preSize > 0;
        dropped = 1'b0;
        mIrq    = mIrqEn && preSize == 0 && wasIdle;
        if (!wasIdle) begin
            frameClk++;
            if (frameClk == 10 * mDiv) frameClk = -1;
        end
        if (popNow) begin
            b         = mq.pop_front();
            frameBits = {1'b1, b, 1'b0};
            mDiv      = mBaud;
            frameClk  = 0;
        end
        if (bus.write_enable && a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: if (preSize < DEPTH || popNow) mq.push_back(d[7:0]); else dropped = 1'b1;
                2'd1: if (d[3]) mOvf = 1'b0;
                2'd2: if (bus.DATAMEMControl == SW) mBaud = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
                default: if (bus.DATAMEMControl == SW) mIrqEn = d[0];
            endcase
        end
        if (dropped) mOvf = 1'b1;
    endtask

    // Advance the model on every clock edge; reset clears it asynchronously
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mq.delete();
            frameClk = -1;
            frameBits = '1;
            mDiv = 1;
            mBaud = 868;
            mOvf = 1'b0;
            mIrqEn = 1'b0;
            mIrq = 1'b0;
        end else begin
            modelStep();
        end
    end

    function automatic logic expTx();
        if (frameClk < 0) return 1'b1;
        return frameBits[frameClk / mDiv];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] word, b, h;
        int sz;
        if (a[31:4] != BASE[31:4]) return 32'd0;
        sz = mq.size();
        case (a[3:2])
            2'd1: word = 32'((sz > 15 ? 15 : sz) * 16 + (mOvf ? 8 : 0) + (sz == 0 ? 4 : 0)
                             + (sz == DEPTH ? 2 : 0) + (frameClk >= 0 ? 1 : 0));
            2'd2: word = 32'(mBaud);
            2'd3: word = {31'd0, mIrqEn};
            default: word = 32'd0;
        endcase
        b = (word >> (8 * a[1:0])) & 32'hFF;
        h = (word >> (16 * a[1])) & 32'hFFFF;
        case (c)
            SB:      return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            LBU:     return b;
            SH:      return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            LHU:     return h;
            SW:      return word;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Serial line and interrupt are compared against the model every cycle
    always @(negedge clk_i) begin
        if (chkEn && !rst_i) begin
            checkOutput("tx", {31'd0, tx_o}, {31'd0, expTx()});
            checkOutput("irq", {31'd0, irq_o}, {31'd0, mIrq});
        end
    end

    // One store cycle; entered and left just after a falling edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        bus.address        = a;
        bus.write_data     = d;
        bus.DATAMEMControl = c;
        bus.write_enable   = 1'b1;
        @(negedge clk_i);
        bus.write_enable   = 1'b0;
    endtask

    task automatic loadCheck(input string tag, input logic [31:0] a, input logic [2:0] c);
        bus.address        = a;
        bus.DATAMEMControl = c;
        bus.write_enable   = 1'b0;
        #1;
        checkOutput(tag, bus.read_data, modelRead(a, c));
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((frameClk >= 0 || mq.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drainInTime", {31'd0, n < budget}, 32'd1);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bus.address = '0;
        bus.write_data = '0;
        bus.write_enable = 1'b0;
        bus.DATAMEMControl = SW;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chkEn = 1'b1;

        $display("[TB] reset values");
        loadCheck("rstBaud", BASE + 32'h8, SW);
        checkOutput("rstBaudConst", bus.read_data, 32'd868);
        loadCheck("rstStatus", BASE + 32'h4, SW);
        checkOutput("rstStatusConst", bus.read_data, 32'h4);
        checkOutput("rstTx", {31'd0, tx_o}, 32'd1);

        $display("[TB] single frame 0xA5");
        applyStimulus(BASE + 32'h8, 32'd4, SW);
        applyStimulus(BASE, 32'hA5, SB);
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            loadCheck("frameStatus", BASE + 32'h4, SW);
            checkOutput("frameBusy", {31'd0, bus.read_data[0]}, 32'd1);
            repeat (4) @(negedge clk_i);
        end
        waitDrain(200);

        $display("[TB] overflow");
        for (int i = 0; i < 10; i++) applyStimulus(BASE, $urandom, SB);
        loadCheck("ovfStatus", BASE + 32'h4, SW);
        checkOutput("ovfSet", {31'd0, bus.read_data[3]}, 32'd1);
        applyStimulus(BASE + 32'h4, 32'h8, SW);
        loadCheck("ovfClrStatus", BASE + 32'h4, SW);
        checkOutput("ovfClr", {31'd0, bus.read_data[3]}, 32'd0);
        waitDrain(1000);

        $display("[TB] push into full FIFO on pop edge");
        for (int i = 0; i < 9; i++) applyStimulus(BASE, $urandom, SB);
        loadCheck("fullStatus", BASE + 32'h4, SW);
        checkOutput("fullBit", {31'd0, bus.read_data[1]}, 32'd1);
        n = 0;
        while (!(frameClk < 0 && mq.size() > 0) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("popEdgeFound", {31'd0, n < 200}, 32'd1);
        applyStimulus(BASE, 32'h3C, SB);
        loadCheck("simulStatus", BASE + 32'h4, SW);
        checkOutput("simulCount", {28'd0, bus.read_data[7:4]}, 32'd8);
        checkOutput("simulOvf", {31'd0, bus.read_data[3]}, 32'd0);
        waitDrain(1000);

        $display("[TB] load lanes");
        applyStimulus(BASE + 32'h8, 32'h0000_8001, SW);
        loadCheck("lb9", BASE + 32'h9, SB);
        checkOutput("lb9Const", bus.read_data, 32'hFFFF_FF80);
        loadCheck("lbu9", BASE + 32'h9, LBU);
        checkOutput("lbu9Const", bus.read_data, 32'h80);
        loadCheck("lh8", BASE + 32'h8, SH);
        checkOutput("lh8Const", bus.read_data, 32'hFFFF_8001);
        loadCheck("lhu8", BASE + 32'h8, LHU);
        loadCheck("undefCode", BASE + 32'h8, 3'b011);
        loadCheck("outside", BASE + 32'h28, SW);
        checkOutput("outsideConst", bus.read_data, 32'd0);
        applyStimulus(BASE + 32'h8, 32'd7, SB);
        loadCheck("sbIgnored", BASE + 32'h8, SW);
        checkOutput("sbIgnoredConst", bus.read_data, 32'h8001);
        applyStimulus(BASE + 32'h8, 32'd0, SW);
        loadCheck("divZero", BASE + 32'h8, SW);
        checkOutput("divZeroConst", bus.read_data, 32'd1);
        applyStimulus(BASE + 32'h8, 32'd3, SW);

        $display("[TB] interrupt and mid-frame reset");
        applyStimulus(BASE + 32'hC, 32'd1, SW);
        @(negedge clk_i);
        checkOutput("irqIdle", {31'd0, irq_o}, 32'd1);
        applyStimulus(BASE, 32'h5A, SB);
        waitDrain(200);
        checkOutput("irqDrained", {31'd0, irq_o}, 32'd1);
        applyStimulus(BASE, 32'h00, SB);
        applyStimulus(BASE, 32'h11, SB);
        repeat (8) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rstMidTx", {31'd0, tx_o}, 32'd1);
        checkOutput("rstMidIrq", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        loadCheck("rstMidStatus", BASE + 32'h4, SW);
        checkOutput("rstMidStatusConst", bus.read_data, 32'h4);
        applyStimulus(BASE + 32'h8, 32'd2, SW);
        applyStimulus(BASE, 32'hC3, SB);
        waitDrain(200);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 6; r++) begin
            logic [2:0] codes [3];
            codes[0] = SB; codes[1] = SH; codes[2] = SW;
            applyStimulus(BASE + 32'h8, 32'($urandom_range(1, 4)), SW);
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) begin
                applyStimulus(BASE, $urandom, codes[$urandom_range(0, 2)]);
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                if ($urandom_range(0, 1) == 1)
                    loadCheck("rndLoad", BASE + 32'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            end
            loadCheck("rndStatus", BASE + 32'h4, SW);
            applyStimulus(BASE + 32'h4, 32'h8, SB);
            waitDrain(800);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
